// File: rtl/result_display_pkg.sv
// result_display_pkg: FSM states and active-low seven-segment codes for the result display.
package result_display_pkg;

    typedef enum logic [1:0] {
        BLANK,
        SHOW,
        OVF
    } state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] digit_seg(input logic [3:0] mag);
        case (mag)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/result_display_seg7_decode.sv
// seg7_decode: picks the segment pattern for one digit slot of the signed result display.
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] mag,
    input  logic       neg,
    input  logic       ov,
    input  logic [1:0] idx,
    output logic [6:0] seg
);

    assign seg = idx == 2'd0      ? digit_seg(mag) :
                 idx == 2'd1      ? (neg ? SEG_MINUS : SEG_BLANK) :
                 idx == 2'd3 && ov ? SEG_E :
                 SEG_BLANK;

endmodule

// File: rtl/result_display.sv
// result_display: latches a signed 4-bit result plus overflow and scans it onto a 4-digit seven-segment display.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_TICKS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data,
    input  logic       OV,
    input  logic       load,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

    state_t        state, state_n;
    logic [RW-1:0] refresh;
    logic [1:0]    idx;
    logic [BW-1:0] blink;
    logic          blink_off;
    logic [3:0]    data_q;
    logic          ov_q;
    logic          wrap;
    logic          blink_last;
    logic          ovf_entry;
    logic [3:0]    mag;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;

    assign wrap       = refresh == RW'(REFRESH_DIV - 1);
    assign blink_last = blink == BW'(BLINK_TICKS - 1);
    assign mag        = data_q[3] ? ~data_q + 4'd1 : data_q;
    assign dp         = 1'b1;

    seg7_decode u_dec (
        .mag (mag),
        .neg (data_q[3]),
        .ov  (ov_q),
        .idx (idx),
        .seg (seg_dec)
    );

    // Every load lands in SHOW or OVF purely by its OV flag, whatever the current state.
    always_comb begin
        state_n   = load ? (OV ? OVF : SHOW) : state;
        ovf_entry = state_n == OVF && state != OVF;
        an_d      = 4'hF;
        seg_d     = SEG_BLANK;
        if (state == SHOW || (state == OVF && !blink_off)) begin
            an_d  = ~(4'b0001 << idx);
            seg_d = seg_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BLANK;
            refresh   <= '0;
            idx       <= '0;
            blink     <= '0;
            blink_off <= 1'b0;
            data_q    <= '0;
            ov_q      <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= 4'hF;
        end else begin
            state   <= state_n;
            refresh <= wrap ? '0 : refresh + 1'b1;
            idx     <= idx + 2'(wrap);
            if (load) begin
                data_q <= data;
                ov_q   <= OV;
            end
            if (ovf_entry) begin
                blink     <= '0;
                blink_off <= 1'b0;
            end else if (state == OVF && wrap) begin
                blink     <= blink_last ? '0 : blink + 1'b1;
                blink_off <= blink_off ^ blink_last;
            end
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb_result_display: scoreboard bench comparing the scanned display against a time-based reference model.
module tb_result_display;

    localparam int DIV = 4;
    localparam int BT  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       OV = 1'b0;
    logic [3:0] data = 4'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    result_display #(.REFRESH_DIV(DIV), .BLINK_TICKS(BT)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .OV   (OV),
        .load (load),
        .seg  (seg),
        .an   (an),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    logic [6:0] digits [0:8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

    // Model: mode 0 blank, 1 show, 2 overflow; n counts edges since reset, wraps counts slots since overflow began.
    int m_mode = 0;
    int m_val = 0;
    bit m_ov = 1'b0;
    int m_n = 0;
    int m_wraps = 0;

    function automatic exp_t predict();
        exp_t e;
        int   slot;
        int   mag;
        e.seg = 7'h7F;
        e.an  = 4'hF;
        slot  = (m_n / DIV) % 4;
        if (m_mode == 1 || (m_mode == 2 && ((m_wraps / BT) % 2) == 0)) begin
            mag   = m_val < 0 ? -m_val : m_val;
            e.an  = 4'hF ^ 4'(1 << slot);
            e.seg = slot == 0 ? digits[mag] :
                    slot == 1 ? (m_val < 0 ? 7'h3F : 7'h7F) :
                    (slot == 3 && m_ov) ? 7'h06 : 7'h7F;
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit l, input logic [3:0] d, input bit o);
        int nxt;
        @(negedge clk);
        rst  = r;
        load = l;
        data = d;
        OV   = o;
        if (r) begin
            q.push_back('{seg: 7'h7F, an: 4'hF});
            m_mode  = 0;
            m_val   = 0;
            m_ov    = 1'b0;
            m_n     = 0;
            m_wraps = 0;
        end else begin
            q.push_back(predict());
            nxt = l ? (o ? 2 : 1) : m_mode;
            m_n++;
            if (nxt == 2 && m_mode != 2)
                m_wraps = 0;
            else if (m_mode == 2 && m_n % DIV == 0)
                m_wraps++;
            m_mode = nxt;
            if (l) begin
                m_val = int'($signed(d));
                m_ov  = o;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (seg !== e.seg || an !== e.an || dp !== 1'b1) begin
                fails++;
                $display("FAIL display cyc=%0d: got seg=%h an=%h dp=%b, expected seg=%h an=%h dp=1",
                         cyc, seg, an, dp, e.seg, e.an);
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(40);
        step(1'b0, 1'b1, 4'b0011, 1'b0);
        idle(40);
        step(1'b0, 1'b1, 4'b1000, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 4'b1101, 1'b1);
        idle(48);
        step(1'b1, 1'b1, 4'b0101, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 4'b0010, 1'b0);
        idle(7);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        idle(24);
        step(1'b0, 1'b1, 4'b0111, 1'b1);
        idle(13);
        step(1'b0, 1'b1, 4'b1001, 1'b1);
        idle(30);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        idle(6);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
        idle(3);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal range >= 2.
REQ-002 Parameter BLINK_TICKS, default 256: digit slots per blink half-period; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data  input  4  signed two's-complement adder/subtractor result, range -8..+7.
REQ-006 OV  input  1  overflow flag accompanying data.
REQ-007 load  input  1  capture strobe; data and OV sampled on any clk edge where load=1.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  4  digit anode enables, active-low; an[0] is the rightmost digit.
REQ-010 dp  output  1  decimal point, active-low; held 1 (off) at all times.

Function
REQ-011 On a load=1 edge the block SHALL register data and OV; the new value SHALL drive seg no later than the second clk edge after capture.
REQ-012 Magnitude SHALL be data when data[3]=0, and the 4-bit negation of data otherwise; -8 SHALL display as 8.
REQ-013 Digit map: an[0] shows magnitude 0..8; an[1] shows '-' if data[3]=1, else blank; an[2] is always blank; an[3] shows 'E' if latched OV=1, else blank.
REQ-014 Segment codes (hex, seg[6:0]): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, '-'=3F, 'E'=06, blank=7F.
REQ-015 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on each wrap the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-016 FSM states: BLANK, SHOW, OVF.
REQ-017 BLANK: an=F, seg=7F. Transition on load: to SHOW if OV=0, to OVF if OV=1.
REQ-018 SHOW: exactly one an bit low, matching the digit index. Transition on load with OV=1 to OVF; otherwise stay in SHOW.
REQ-019 OVF: scan as in SHOW, but a blink counter, advancing on each refresh wrap, SHALL toggle visibility every BLINK_TICKS slots. During the off phase an=F. Transition on load with OV=0 to SHOW.
REQ-020 OVF entry SHALL reset the blink counter to 0 and the phase to visible.
REQ-021 load SHALL NOT reset the refresh counter or the digit index; scanning continues unbroken.
REQ-022 seg and an SHALL be registered outputs, delayed one cycle from the index and state.
REQ-023 Back-to-back loads SHALL each capture; the last one wins.

Reset
REQ-024 When rst=1: state=BLANK; refresh, index and blink counters=0; captured data=0; captured OV=0; seg=7F; an=F; dp=1 on the next edge.
REQ-025 rst SHALL override a simultaneous load; the value is discarded.
REQ-026 A reset mid-scan or mid-blink SHALL return the block to BLANK with no partial digit held.

Structure
REQ-027 Package result_display_pkg SHALL hold the FSM state enum and the segment code constants of REQ-014.
REQ-028 A combinational sub-module seg7_decode SHALL map {magnitude, sign, OV, digit index} to seg; all sequencing stays in result_display.

Verification (REFRESH_DIV=4, BLINK_TICKS=2)
REQ-029 Reset then idle 40 cycles -> an=F, seg=7F, dp=1 throughout.
REQ-030 load data=0011, OV=0 -> state SHOW; an cycles E,D,B,7 with each value held 4 cycles; seg=30 while an=E; seg=7F while an=D, B and 7.
REQ-031 load data=1000, OV=0 -> seg=00 while an=E; seg=3F while an=D.
REQ-032 load data=1101, OV=1 -> seg=30 while an=E; seg=3F while an=D; seg=06 while an=7. Display dark (an=F) for 8 cycles after every 8 visible cycles.
REQ-033 rst asserted together with load data=0101 during OVF -> next edge an=F, seg=7F; the following idle cycles stay BLANK.
REQ-034 Loads of 0001 then 0110 on consecutive cycles during SHOW -> scan phase unbroken; seg=02 on the next an=E slot.
